// File: rtl/mc_alu_control_if.sv
// mc_alu_control_if
//   Bundle between the multi-cycle MIPS main control FSM and the datapath.
//   master modport : the controller (samples opcode/mem_ready, drives strobes)
//   slave modport  : the datapath/memory side (drives opcode/mem_ready)
//   Signals:
//     opcode      IR[31:26], meaningful from DECODE onward
//     mem_ready   memory finishes the current read/write this cycle
//     PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0],
//     PCSource[1:0]  datapath mux selects and enables
//     illegal_op  one-cycle pulse for an undecodable opcode
//     state_dbg   current FSM state encoding
interface mc_alu_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state_dbg
  );
endinterface

// File: rtl/mc_alu_control.sv
// mc_alu_control
//   Multi-cycle MIPS main control FSM. Sequences the shared ALU, register
//   file, PC/IR registers and the unified memory port, one state per cycle.
//   Memory states stall on mem_ready.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; forces every output to 0 and the
//            state to FETCH
//     bus    mc_alu_control_if.master: opcode/mem_ready in, strobes out
//   Build option:
//     ADDI_EN  when defined, addi executes through ADDIEX/ADDIWB; otherwise
//              addi is an illegal opcode and encodings 10/11 are unused.
module mc_alu_control (
  input  logic              clk,
  input  logic              reset,
  mc_alu_control_if.master  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
`ifdef ADDI_EN
    ,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
`endif
  } state_t;

  state_t state;

  // Opcodes DECODE knows how to dispatch.
  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef ADDI_EN
      OP_ADDI: ok = 1'b1;
`else
      OP_ADDI: ok = 1'b0;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // State register with next-state decode. Unused encodings fall back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
`ifdef ADDI_EN
            OP_ADDI:      state <= S_ADDIEX;
`endif
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (bus.opcode == OP_LW)      state <= S_MEMRD;
          else if (bus.opcode == OP_SW) state <= S_MEMWR;
          else                          state <= S_FETCH;
        end
        S_MEMRD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_RWB;
        S_RWB:    state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
`ifdef ADDI_EN
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
`endif
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the strobes. FETCH's IRWrite/PCWrite follow mem_ready
  // so PC+4 and the IR load happen only on the cycle the fetch completes.
  // Reset gates everything to 0 because FETCH itself would assert MemRead.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegal_op  = 1'b0;
    bus.state_dbg   = state;
    case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target (PC + imm<<2) into ALUOut.
        bus.ALUSrcB    = 2'b11;
        bus.illegal_op = ~op_legal(bus.opcode);
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
`ifdef ADDI_EN
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        bus.RegWrite = 1'b1;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.ALUOp       = 2'b00;
      bus.PCSource    = 2'b00;
      bus.illegal_op  = 1'b0;
      bus.state_dbg   = 4'd0;
    end
  end

endmodule

// File: tb/tb_mc_alu_control.sv
// tb_mc_alu_control
//   Drives mc_alu_control one instruction at a time. For each instruction the
//   bench expands the opcode and chosen memory-wait counts into the list of
//   cycles the instruction must take (state, strobes, mem_ready to apply),
//   then plays that list into the DUT and compares every cycle.
module tb_mc_alu_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] o;
    logic        mr;
    logic [5:0]  op;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_alu_control_if bus();

  mc_alu_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op}
  logic [16:0] dut_o;
  assign dut_o = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                  bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                  bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                  bus.PCSource, bus.illegal_op};

  int checks = 0;
  int passes = 0;
  cyc_t q[$];
  int   st_log[$];
  int   cnt_irw, cnt_pcw, cnt_mrd, cnt_mwr, cnt_pcs10, cnt_ill, cnt_alu10, cnt_rwb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [16:0] outs(
    input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
    input logic [1:0] srcb, aluop, pcsrc, input logic ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ill};
  endfunction

  function automatic void push(input int st, input logic [16:0] o, input logic mr,
                               input logic [5:0] op);
    cyc_t c;
    c.st = st[3:0]; c.o = o; c.mr = mr; c.op = op;
    q.push_back(c);
  endfunction

  function automatic logic legal(input logic [5:0] op);
`ifdef ADDI_EN
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
`else
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J};
`endif
  endfunction

  // Expand one instruction into its expected cycle list.
  function automatic void build(input logic [5:0] op, input int wf, input int wm);
    logic r;
    for (int i = 0; i < wf; i++)
      push(0, outs(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b0, 6'($urandom));
    push(0, outs(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, 6'($urandom));
    r = 1'($urandom);
    push(1, outs(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,~legal(op)), r, op);
    if (!legal(op)) return;
    if (op == OP_LW || op == OP_SW) begin
      push(2, outs(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'($urandom), op);
      for (int i = 0; i <= wm; i++) begin
        if (op == OP_LW)
          push(3, outs(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), (i == wm), op);
        else
          push(5, outs(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), (i == wm), op);
      end
      if (op == OP_LW)
        push(4, outs(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), 1'($urandom), op);
    end else if (op == OP_RTYPE) begin
      push(6, outs(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), 1'($urandom), op);
      push(7, outs(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), 1'($urandom), op);
    end else if (op == OP_BEQ) begin
      push(8, outs(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), 1'($urandom), op);
    end else if (op == OP_J) begin
      push(9, outs(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), 1'($urandom), op);
    end else begin
      push(10, outs(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'($urandom), op);
      push(11, outs(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), 1'($urandom), op);
    end
  endfunction

  // Called at a falling edge; plays the cycle list, returns at a falling edge
  // (or mid-cycle when limit cuts the instruction short).
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int limit);
    int n;
    q.delete();
    build(op, wf, wm);
    n = (limit > 0 && limit < q.size()) ? limit : q.size();
    st_log.delete();
    cnt_irw = 0; cnt_pcw = 0; cnt_mrd = 0; cnt_mwr = 0;
    cnt_pcs10 = 0; cnt_ill = 0; cnt_alu10 = 0; cnt_rwb = 0;
    for (int i = 0; i < n; i++) begin
      bus.opcode    = q[i].op;
      bus.mem_ready = q[i].mr;
      #1;
      check("state_dbg", 32'(bus.state_dbg), 32'(q[i].st));
      check("strobes",   32'(dut_o),         32'(q[i].o));
      st_log.push_back(int'(bus.state_dbg));
      if (bus.IRWrite) cnt_irw++;
      if (bus.PCWrite) cnt_pcw++;
      if (bus.MemRead) cnt_mrd++;
      if (bus.MemWrite && bus.IorD) cnt_mwr++;
      if (bus.PCSource == 2'b10) cnt_pcs10++;
      if (bus.illegal_op) cnt_ill++;
      if (bus.ALUOp == 2'b10) cnt_alu10++;
      if (bus.RegWrite && bus.RegDst) cnt_rwb++;
      if (!(limit > 0 && i == n - 1)) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outs"}, 32'(dut_o), 32'd0);
    check({name, "_state"}, 32'(bus.state_dbg), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b000000;

    // Hand-computed instruction lengths with mem_ready tied high.
    q.delete(); build(OP_LW, 0, 0);   check("len_lw",   q.size(), 5);
    q.delete(); build(OP_SW, 0, 0);   check("len_sw",   q.size(), 4);
    q.delete(); build(OP_RTYPE, 0, 0);check("len_r",    q.size(), 4);
    q.delete(); build(OP_BEQ, 0, 0);  check("len_beq",  q.size(), 3);
    q.delete(); build(OP_J, 0, 0);    check("len_j",    q.size(), 3);
`ifdef ADDI_EN
    q.delete(); build(OP_ADDI, 0, 0); check("len_addi", q.size(), 4);
`else
    q.delete(); build(OP_ADDI, 0, 0); check("len_addi", q.size(), 2);
`endif
    q.delete(); build(OP_LW, 2, 3);   check("len_lw_wait", q.size(), 10);

    // Reset held three cycles with mem_ready high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_reset_outputs("in_reset");
    end
    @(negedge clk);
    reset = 1'b0;

    // R-type right out of reset.
    run_instr(OP_RTYPE, 0, 0, 0);
    check("r_seq_len", st_log.size(), 4);
    check("r_seq0", st_log[0], 0);
    check("r_seq1", st_log[1], 1);
    check("r_seq2", st_log[2], 6);
    check("r_seq3", st_log[3], 7);
    check("r_aluop10_cycles", cnt_alu10, 1);
    check("r_rwb_cycles", cnt_rwb, 1);
    #1 check("r_back_to_fetch", 32'(bus.state_dbg), 32'd0);

    // lw with 2 fetch waits and 3 memory waits.
    run_instr(OP_LW, 2, 3, 0);
    check("lw_cycles", st_log.size(), 10);
    check("lw_irwrite_once", cnt_irw, 1);
    check("lw_pcwrite_once", cnt_pcw, 1);
    check("lw_memread_cycles", cnt_mrd, 7);

    run_instr(OP_SW, 0, 0, 0);
    check("sw_memwrite_once", cnt_mwr, 1);
    run_instr(OP_BEQ, 0, 0, 0);
    check("beq_state2", st_log[2], 8);

    run_instr(OP_J, 0, 0, 0);
    check("j_pcsource10_once", cnt_pcs10, 1);
    check("j_state2", st_log[2], 9);

    run_instr(6'b111111, 0, 0, 0);
    check("illegal_pulse_once", cnt_ill, 1);
    #1 check("illegal_back_to_fetch", 32'(bus.state_dbg), 32'd0);

    run_instr(OP_ADDI, 0, 0, 0);
`ifdef ADDI_EN
    check("addi_illegal_cnt", cnt_ill, 0);
    check("addi_state2", st_log[2], 10);
`else
    check("addi_illegal_cnt", cnt_ill, 1);
    check("addi_len", st_log.size(), 2);
`endif

    // Reset in MEMWR while memory is stalled: FETCH, DECODE, MEMADR, MEMWR(wait).
    run_instr(OP_SW, 0, 5, 4);
    check("pre_reset_memwrite", 32'(bus.MemWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk); #1;
    check_reset_outputs("async_reset_hold");
    @(negedge clk);
    reset = 1'b0;
    run_instr(OP_RTYPE, 1, 0, 0);

    // Randomized instruction stream.
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 7))
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        6: op = OP_LW;
        default: op = 6'($urandom);
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mc_alu_control.md
Name: mc_alu_control

Overview:
- Multi-cycle MIPS main control FSM that sequences the shared ALU, register file, PC/IR registers and unified memory port.
- Decodes opcode from IR; drives ALUOp (00 add for lw/sw/PC+4, 01 sub for beq compare, 10 funct-decoded) and all datapath mux/enable strobes, one state per cycle.
- Stalls on a memory ready handshake.
- Sits between the instruction register and the datapath; the ALU's own funct decode stays in the ALU.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode (used only with ADDI_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero=1
- IorD  out  1  0: memory address=PC, 1: ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  regfile write data from MDR
- RegDst  out  1  1: rd, 0: rt
- RegWrite  out  1  regfile write enable
- ALUSrcA  out  1  0: PC, 1: A register
- ALUSrcB  out  2  00: B, 01: const 4, 10: sign-ext imm, 11: sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct
- PCSource  out  2  00: ALU result, 01: ALUOut, 10: jump target
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- state_dbg  out  4  current state encoding

Behaviour:
- State register is 4 bits; all outputs are Moore-decoded from state, except handshake-gated strobes.
- Reset: asynchronous to FETCH. While reset=1, every output is forced 0 and state_dbg=0.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX (ADDI_EN only).
  - Any other opcode→FETCH with illegal_op=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if lw, MEMWR if sw.
- MEMRD: MemRead=1, IorD=1; hold until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
- MEMWR: MemWrite=1, IorD=1; hold until mem_ready=1, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
- JUMP: PCWrite=1, PCSource=10; next FETCH.
- Outputs not listed for a state are 0.
- Unused state encodings (12-15) return to FETCH next cycle with all outputs 0.
- Cycle counts with mem_ready tied to 1:
  - lw=5, sw=4, R=4, beq=3, j=3, addi=4.
  - Each memory wait cycle adds 1.
- mem_ready=1 outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-instruction aborts it; no partial RegWrite/MemWrite is emitted after reset.
- opcode is sampled only in DECODE and MEMADR (IR is stable there).

Optional Feature:
- Macro ADDI_EN.
- Defined:
  - DECODE routes OP_ADDI to ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00).
  - Then ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0), then FETCH.
- Undefined:
  - ADDIEX/ADDIWB are not built.
  - OP_ADDI is illegal: DECODE→FETCH with illegal_op pulse; encodings 10/11 behave as unused states.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 and opcode=000000 → all outputs 0 during reset.
  - Then state_dbg sequence 0,1,6,7,0.
  - ALUOp=10 in EXEC; RegWrite=1, RegDst=1 in RWB.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD → 10 cycles total.
  - IRWrite/PCWrite asserted exactly once.
  - MemRead held high across waits; RegWrite+MemtoReg in MEMWB.
- sw (101011) then beq (000100) with mem_ready=1 → MemWrite=1 with IorD=1 for exactly 1 cycle.
  - beq state sequence 0,1,8, with ALUOp=01, PCWriteCond=1, PCSource=01.
- j (000010) → state sequence 0,1,9,0; PCWrite=1 and PCSource=10 only in JUMP.
- opcode=111111 → illegal_op=1 for exactly one cycle in DECODE, then state 0.
  - Repeat with 001000: result follows ADDI_EN (path 0,1,10,11,0 if defined, illegal pulse if not).
- Reset asserted in MEMWR while mem_ready=0 → state_dbg=0 and MemWrite=0 immediately (asynchronous).
  - After release, normal fetch resumes.
